multicycle_control: RTL and testbench

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

---
 rtl/mips_ctrl_pkg.sv | 77 +++++++
 rtl/multicycle_control_if.sv | 33 +++
 rtl/mc_next_state.sv | 37 +++
 rtl/multicycle_control.sv | 113 +++++++++++
 tb/tb_multicycle_control.sv | 296 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mips_ctrl_pkg.sv
// mips_ctrl_pkg: shared encodings for the multicycle MIPS control unit.
// Optional feature macro: JUMP_INSN_EN (adds the JUMP state and makes j legal).
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    ST_RST    = 4'd0,
    ST_FETCH  = 4'd1,
    ST_DECODE = 4'd2,
    ST_MEMADR = 4'd3,
    ST_MEMRD  = 4'd4,
    ST_MEMWB  = 4'd5,
    ST_MEMWR  = 4'd6,
    ST_EXEC   = 4'd7,
    ST_RWB    = 4'd8,
    ST_BRANCH = 4'd9
`ifdef JUMP_INSN_EN
    ,
    ST_JUMP   = 4'd10
`endif
  } stateT;

`ifdef JUMP_INSN_EN
  localparam bit JUMP_EN = 1'b1;
`else
  localparam bit JUMP_EN = 1'b0;
`endif

  // Opcode field values
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  // ALUOp codes
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // ALUSrcB codes
  localparam logic [1:0] SRCB_REG   = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_SHIMM = 2'b11;

  // PCSource codes
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // State-decoded control word. fetchWrite marks the FETCH strobes
  // (IRWrite and PCWrite) that are only asserted once memory is ready.
  typedef struct packed {
    logic       pcWrite;
    logic       fetchWrite;
    logic       pcWriteCond;
    logic       iorD;
    logic       memRead;
    logic       memWrite;
    logic       memtoReg;
    logic       regWrite;
    logic       regDst;
    logic       aluSrcA;
    logic [1:0] pcSource;
    logic [1:0] aluOp;
    logic [1:0] aluSrcB;
  } ctrlT;

  // True for opcodes the controller knows how to sequence.
  function automatic logic opSupported(input logic [5:0] op);
    logic ok;
    ok = (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) || (op == OP_BEQ) ||
         ((op == OP_J) && JUMP_EN);
    return ok;
  endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// multicycle_control_if: controller <-> datapath signal bundle.
// slave = controller side, master = datapath (or bench) side.
interface multicycle_control_if;
  logic [5:0] Op;
  logic       mem_ready;
  logic       PCWrite;
  logic       PCWriteCond;
  logic       IorD;
  logic       MemRead;
  logic       MemWrite;
  logic       IRWrite;
  logic       MemtoReg;
  logic       RegWrite;
  logic       RegDst;
  logic       ALUSrcA;
  logic [1:0] PCSource;
  logic [1:0] ALUOp;
  logic [1:0] ALUSrcB;
  logic       illegal_op;
  logic [3:0] state;

  modport slave (
    input  Op, mem_ready,
    output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
           RegWrite, RegDst, ALUSrcA, PCSource, ALUOp, ALUSrcB, illegal_op, state
  );

  modport master (
    output Op, mem_ready,
    input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
           RegWrite, RegDst, ALUSrcA, PCSource, ALUOp, ALUSrcB, illegal_op, state
  );
endinterface

// File: rtl/mc_next_state.sv
// mc_next_state: combinational transition logic of the multicycle controller.
// Optional feature macro: JUMP_INSN_EN (DECODE of j goes to JUMP).
module mc_next_state
  import mips_ctrl_pkg::*;
(
  input  stateT      curState,
  input  logic [5:0] op,
  input  logic       memReady,
  output stateT      nextState
);

  // Next state; memReady is only looked at in FETCH, MEMRD and MEMWR.
  always_comb begin
    nextState = ST_FETCH;
    case (curState)
      ST_RST:    nextState = ST_FETCH;
      ST_FETCH:  nextState = memReady ? ST_DECODE : ST_FETCH;
      ST_DECODE: begin
        case (op)
          OP_LW, OP_SW: nextState = ST_MEMADR;
          OP_RTYPE:     nextState = ST_EXEC;
          OP_BEQ:       nextState = ST_BRANCH;
`ifdef JUMP_INSN_EN
          OP_J:         nextState = ST_JUMP;
`endif
          default:      nextState = ST_FETCH;
        endcase
      end
      ST_MEMADR: nextState = (op == OP_LW) ? ST_MEMRD : ST_MEMWR;
      ST_MEMRD:  nextState = memReady ? ST_MEMWB : ST_MEMRD;
      ST_MEMWR:  nextState = memReady ? ST_FETCH : ST_MEMWR;
      ST_EXEC:   nextState = ST_RWB;
      default:   nextState = ST_FETCH;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// multicycle_control: Moore FSM sequencing a multicycle MIPS datapath
// (lw, sw, R-type, beq and optionally j).
// Optional feature macro: JUMP_INSN_EN (adds the JUMP state for j).
module multicycle_control
  import mips_ctrl_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  multicycle_control_if.slave   bus
);

  stateT state;
  stateT nextState;
  ctrlT  ctrlQ;

  mc_next_state uNextState (
    .curState  (state),
    .op        (bus.Op),
    .memReady  (bus.mem_ready),
    .nextState (nextState)
  );

  // Control word for a state; anything not set here stays 0.
  function automatic ctrlT decodeState(input stateT s);
    ctrlT c;
    c = '0;
    case (s)
      ST_FETCH: begin
        c.memRead    = 1'b1;
        c.fetchWrite = 1'b1;
        c.aluSrcB    = SRCB_FOUR;
        c.aluOp      = ALUOP_ADD;
        c.pcSource   = PCSRC_ALU;
      end
      ST_DECODE: begin
        c.aluSrcB = SRCB_SHIMM;
        c.aluOp   = ALUOP_ADD;
      end
      ST_MEMADR: begin
        c.aluSrcA = 1'b1;
        c.aluSrcB = SRCB_IMM;
        c.aluOp   = ALUOP_ADD;
      end
      ST_MEMRD: begin
        c.memRead = 1'b1;
        c.iorD    = 1'b1;
      end
      ST_MEMWB: begin
        c.regWrite = 1'b1;
        c.memtoReg = 1'b1;
      end
      ST_MEMWR: begin
        c.memWrite = 1'b1;
        c.iorD     = 1'b1;
      end
      ST_EXEC: begin
        c.aluSrcA = 1'b1;
        c.aluSrcB = SRCB_REG;
        c.aluOp   = ALUOP_FUNCT;
      end
      ST_RWB: begin
        c.regWrite = 1'b1;
        c.regDst   = 1'b1;
      end
      ST_BRANCH: begin
        c.aluSrcA     = 1'b1;
        c.aluSrcB     = SRCB_REG;
        c.aluOp       = ALUOP_SUB;
        c.pcWriteCond = 1'b1;
        c.pcSource    = PCSRC_ALUOUT;
      end
`ifdef JUMP_INSN_EN
      ST_JUMP: begin
        c.pcWrite  = 1'b1;
        c.pcSource = PCSRC_JUMP;
      end
`endif
      default: c = '0;
    endcase
    return c;
  endfunction

  // State register plus the control word registered for the state being entered;
  // async reset clears both so outputs drop to 0 without waiting for clk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_RST;
      ctrlQ <= '0;
    end else begin
      state <= nextState;
      ctrlQ <= decodeState(nextState);
    end
  end

  // FETCH strobes wait for the memory; illegal_op flags DECODE of an unknown opcode.
  assign bus.IRWrite     = ctrlQ.fetchWrite & bus.mem_ready;
  assign bus.PCWrite     = ctrlQ.pcWrite | (ctrlQ.fetchWrite & bus.mem_ready);
  assign bus.illegal_op  = (state == ST_DECODE) && !opSupported(bus.Op);

  assign bus.PCWriteCond = ctrlQ.pcWriteCond;
  assign bus.IorD        = ctrlQ.iorD;
  assign bus.MemRead     = ctrlQ.memRead;
  assign bus.MemWrite    = ctrlQ.memWrite;
  assign bus.MemtoReg    = ctrlQ.memtoReg;
  assign bus.RegWrite    = ctrlQ.regWrite;
  assign bus.RegDst      = ctrlQ.regDst;
  assign bus.ALUSrcA     = ctrlQ.aluSrcA;
  assign bus.PCSource    = ctrlQ.pcSource;
  assign bus.ALUOp       = ctrlQ.aluOp;
  assign bus.ALUSrcB     = ctrlQ.aluSrcB;
  assign bus.state       = state;

endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: vector table, hand sequences and a randomized run
// against an instruction-path reference model.
// Honours JUMP_INSN_EN the same way as the design.
module tb_multicycle_control;
  import mips_ctrl_pkg::*;

  localparam logic [5:0] LW  = 6'b100011;
  localparam logic [5:0] SW  = 6'b101011;
  localparam logic [5:0] RT  = 6'b000000;
  localparam logic [5:0] BEQ = 6'b000100;
  localparam logic [5:0] JMP = 6'b000010;
  localparam logic [5:0] BAD = 6'b111111;

  typedef struct packed {
    logic       pcWrite;
    logic       pcWriteCond;
    logic       iorD;
    logic       memRead;
    logic       memWrite;
    logic       irWrite;
    logic       memtoReg;
    logic       regWrite;
    logic       regDst;
    logic       aluSrcA;
    logic [1:0] pcSource;
    logic [1:0] aluOp;
    logic [1:0] aluSrcB;
    logic       illegal;
  } outT;

  typedef struct {
    logic [5:0] op;
    logic       mr;
    stateT      st;
  } vecT;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   nAssert = 0;
  int   nFail = 0;

  vecT   vecs[$];
  stateT expState;
  stateT pending[$];

  multicycle_control_if busIf ();

  multicycle_control dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (busIf)
  );

  always #5 clk = ~clk;

  function automatic logic legalOp(input logic [5:0] op);
    logic ok;
    ok = (op == LW) || (op == SW) || (op == RT) || (op == BEQ);
`ifdef JUMP_INSN_EN
    ok = ok || (op == JMP);
`endif
    return ok;
  endfunction

  // Output table straight from the state descriptions.
  function automatic outT specOut(input stateT s, input logic [5:0] op, input logic mr);
    outT o;
    o = '0;
    case (s)
      ST_FETCH:  begin o.memRead = 1; o.aluSrcB = 2'b01; o.irWrite = mr; o.pcWrite = mr; end
      ST_DECODE: begin o.aluSrcB = 2'b11; o.illegal = !legalOp(op); end
      ST_MEMADR: begin o.aluSrcA = 1; o.aluSrcB = 2'b10; end
      ST_MEMRD:  begin o.memRead = 1; o.iorD = 1; end
      ST_MEMWB:  begin o.regWrite = 1; o.memtoReg = 1; end
      ST_MEMWR:  begin o.memWrite = 1; o.iorD = 1; end
      ST_EXEC:   begin o.aluSrcA = 1; o.aluOp = 2'b10; end
      ST_RWB:    begin o.regWrite = 1; o.regDst = 1; end
      ST_BRANCH: begin o.aluSrcA = 1; o.aluOp = 2'b01; o.pcWriteCond = 1; o.pcSource = 2'b01; end
`ifdef JUMP_INSN_EN
      ST_JUMP:   begin o.pcWrite = 1; o.pcSource = 2'b10; end
`endif
      default:   o = '0;
    endcase
    return o;
  endfunction

  function automatic outT actOut();
    outT o;
    o.pcWrite     = busIf.PCWrite;
    o.pcWriteCond = busIf.PCWriteCond;
    o.iorD        = busIf.IorD;
    o.memRead     = busIf.MemRead;
    o.memWrite    = busIf.MemWrite;
    o.irWrite     = busIf.IRWrite;
    o.memtoReg    = busIf.MemtoReg;
    o.regWrite    = busIf.RegWrite;
    o.regDst      = busIf.RegDst;
    o.aluSrcA     = busIf.ALUSrcA;
    o.pcSource    = busIf.PCSource;
    o.aluOp       = busIf.ALUOp;
    o.aluSrcB     = busIf.ALUSrcB;
    o.illegal     = busIf.illegal_op;
    return o;
  endfunction

  task automatic checkEq(input string name, input logic [31:0] act, input logic [31:0] exp);
    nAssert++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic atSample();
    @(negedge clk);
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
  endtask

  // Assert reset, check the reset outputs, release; next sampled cycle is RST.
  task automatic doReset();
    rst_n = 1'b0;
    busIf.Op = RT;
    busIf.mem_ready = 1'b0;
    @(posedge clk);
    #1;
    checkEq("reset_state", 32'(busIf.state), 32'(ST_RST));
    checkEq("reset_outputs", 32'(actOut()), 32'd0);
    rst_n = 1'b1;
  endtask

  task automatic addVec(input logic [5:0] op, input logic mr, input stateT st);
    vecT v;
    v.op = op;
    v.mr = mr;
    v.st = st;
    vecs.push_back(v);
  endtask

  // Reference model: each instruction is FETCH, DECODE and then an
  // opcode-specific list of states; memory states repeat until ready.
  function automatic void loadPath(input logic [5:0] op);
    pending.delete();
    case (op)
      LW:  begin pending.push_back(ST_MEMADR); pending.push_back(ST_MEMRD); pending.push_back(ST_MEMWB); end
      SW:  begin pending.push_back(ST_MEMADR); pending.push_back(ST_MEMWR); end
      RT:  begin pending.push_back(ST_EXEC); pending.push_back(ST_RWB); end
      BEQ: pending.push_back(ST_BRANCH);
`ifdef JUMP_INSN_EN
      JMP: pending.push_back(ST_JUMP);
`endif
      default: ;
    endcase
  endfunction

  function automatic void popPath();
    if (pending.size() > 0) expState = pending.pop_front();
    else expState = ST_FETCH;
  endfunction

  function automatic void modelStep(input logic [5:0] op, input logic mr);
    case (expState)
      ST_RST:   expState = ST_FETCH;
      ST_FETCH: if (mr) expState = ST_DECODE;
      ST_DECODE: begin loadPath(op); popPath(); end
      ST_MEMRD, ST_MEMWR: if (mr) popPath();
      default:  popPath();
    endcase
  endfunction

  initial begin
    logic [5:0] opChoices [5];
    logic [5:0] latOps [6];
    int         latExp [6];
    int         cnt;
    int         idx;

    opChoices = '{LW, SW, RT, BEQ, JMP};
    latOps    = '{LW, SW, RT, BEQ, JMP, BAD};
`ifdef JUMP_INSN_EN
    latExp    = '{5, 4, 4, 3, 3, 2};
`else
    latExp    = '{5, 4, 4, 3, 2, 2};
`endif

    // ---- vector table ----
    addVec(RT, 1, ST_RST);   addVec(RT, 1, ST_FETCH);  addVec(RT, 1, ST_DECODE);
    addVec(RT, 1, ST_EXEC);  addVec(RT, 1, ST_RWB);
    addVec(BEQ, 0, ST_FETCH); addVec(BEQ, 1, ST_FETCH); addVec(BEQ, 1, ST_DECODE);
    addVec(BEQ, 1, ST_BRANCH);
    addVec(BAD, 1, ST_FETCH); addVec(BAD, 1, ST_DECODE);
    addVec(JMP, 1, ST_FETCH); addVec(JMP, 1, ST_DECODE);
`ifdef JUMP_INSN_EN
    addVec(JMP, 1, ST_JUMP);
`endif
    addVec(SW, 1, ST_FETCH);  addVec(SW, 0, ST_DECODE); addVec(SW, 0, ST_MEMADR);
    addVec(SW, 0, ST_MEMWR);  addVec(SW, 0, ST_MEMWR);  addVec(SW, 1, ST_MEMWR);
    addVec(LW, 1, ST_FETCH);  addVec(LW, 1, ST_DECODE); addVec(LW, 1, ST_MEMADR);
    addVec(LW, 1, ST_MEMRD);  addVec(LW, 0, ST_MEMWB);  addVec(RT, 0, ST_FETCH);

    doReset();
    foreach (vecs[i]) begin
      busIf.Op = vecs[i].op;
      busIf.mem_ready = vecs[i].mr;
      atSample();
      checkEq($sformatf("vec%0d_state", i), 32'(busIf.state), 32'(vecs[i].st));
      checkEq($sformatf("vec%0d_outputs", i), 32'(actOut()),
              32'(specOut(vecs[i].st, vecs[i].op, vecs[i].mr)));
      advance();
    end

    // ---- lw with three wait cycles in MEMRD ----
    doReset();
    busIf.Op = LW;
    busIf.mem_ready = 1'b1;
    repeat (4) advance();
    busIf.mem_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (k == 3) busIf.mem_ready = 1'b1;
      atSample();
      checkEq($sformatf("lw_wait%0d_state", k), 32'(busIf.state), 32'(ST_MEMRD));
      checkEq($sformatf("lw_wait%0d_rd_iord", k), {30'd0, busIf.MemRead, busIf.IorD}, 32'd3);
      checkEq($sformatf("lw_wait%0d_wr", k), 32'(busIf.MemWrite), 32'd0);
      advance();
    end
    atSample();
    checkEq("lw_wb_state", 32'(busIf.state), 32'(ST_MEMWB));
    checkEq("lw_wb_mtr_rw", {30'd0, busIf.MemtoReg, busIf.RegWrite}, 32'd3);
    advance();
    atSample();
    checkEq("lw_back_to_fetch", 32'(busIf.state), 32'(ST_FETCH));

    // ---- async reset in the middle of a MEMRD wait ----
    advance();
    doReset();
    busIf.Op = LW;
    busIf.mem_ready = 1'b1;
    repeat (4) advance();
    busIf.mem_ready = 1'b0;
    checkEq("midrd_state_before", 32'(busIf.state), 32'(ST_MEMRD));
    checkEq("midrd_memread_before", 32'(busIf.MemRead), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    checkEq("async_rst_state", 32'(busIf.state), 32'(ST_RST));
    checkEq("async_rst_outputs", 32'(actOut()), 32'd0);
    #1 rst_n = 1'b1;
    busIf.mem_ready = 1'b1;
    advance();
    checkEq("after_async_rst_fetch", 32'(busIf.state), 32'(ST_FETCH));

    // ---- instruction latency with mem_ready tied high ----
    for (int k = 0; k < 6; k++) begin
      doReset();
      busIf.Op = latOps[k];
      busIf.mem_ready = 1'b1;
      advance();
      cnt = 0;
      do begin
        cnt++;
        advance();
      end while (busIf.state != 4'(ST_FETCH) && cnt < 20);
      checkEq($sformatf("latency_op%02h", latOps[k]), 32'(cnt), 32'(latExp[k]));
    end

    // ---- randomized run against the path model ----
    doReset();
    expState = ST_RST;
    pending.delete();
    for (int n = 0; n < 800; n++) begin
      if ($urandom_range(0, 79) == 0) begin
        rst_n = 1'b0;
        #1 rst_n = 1'b1;
        expState = ST_RST;
        pending.delete();
      end
      if (expState == ST_FETCH) begin
        idx = $urandom_range(0, 5);
        busIf.Op = (idx == 5) ? 6'($urandom) : opChoices[idx];
      end
      busIf.mem_ready = ($urandom_range(0, 2) != 0);
      atSample();
      checkEq($sformatf("rnd%0d_state", n), 32'(busIf.state), 32'(expState));
      checkEq($sformatf("rnd%0d_outputs", n), 32'(actOut()),
              32'(specOut(expState, busIf.Op, busIf.mem_ready)));
      modelStep(busIf.Op, busIf.mem_ready);
      advance();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
    $finish;
  end

endmodule
